dcache_flush_arbiter: RTL and testbench
=======================================

Name: dcache_flush_arbiter

Overview:
- Shares the single dcache flush/ack handshake between NR_REQ independent flush requesters, e.g. fence, fence.i, fence.t and the debug module.
- Coalesces concurrent requests into one flush and returns a per-requester acknowledge.
- Sits between the flush controller's requesters and the dcache flush port.
- Optional watchdog aborts a flush that the cache never acknowledges.

Parameters:
- NR_REQ, 4, number of requesters (1..16).
- TIMEOUT_CYCLES, 1024, cycles in FLUSH before watchdog abort (watchdog build only; >= 2).
- CNT_WIDTH, 16, width of the completed-flush counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NR_REQ  level flush request per requester; held until its ack_o pulse.
- ack_o  out  NR_REQ  one-cycle completion pulse per requester.
- flush_dcache_o  out  1  flush request to dcache.
- flush_dcache_ack_i  in  1  one-cycle flush-complete pulse from dcache.
- busy_o  out  1  high whenever state != IDLE.
- served_mask_o  out  NR_REQ  snapshot of requesters covered by the current flush.
- flush_cnt_o  out  CNT_WIDTH  completed flushes, saturating.
- timeout_o  out  1  sticky watchdog flag.
- clear_timeout_i  in  1  clears timeout_o.

Behaviour:
- Reset values: all outputs 0; state=IDLE; snapshot=0; counters=0.
- State machine: IDLE -> FLUSH -> ACK -> IDLE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - if |req_i, load snapshot <= req_i and go to FLUSH next cycle.
  - flush_dcache_ack_i is ignored in IDLE.
- FLUSH:
  - flush_dcache_o = 1.
  - when flush_dcache_ack_i = 1, go to ACK.
  - new requests raised during FLUSH are not added to the snapshot.
- ACK (exactly 1 cycle):
  - flush_dcache_o = 0.
  - ack_o = snapshot.
  - flush_cnt_o increments unless it is all-ones.
  - snapshot is cleared on the transition to IDLE.
- Latency:
  - req_i rises in cycle 0 (IDLE) -> flush_dcache_o high from cycle 1.
  - ack_i in cycle k -> ack_o pulse in cycle k+1, IDLE in k+2.
  - earliest next flush_dcache_o: cycle k+3.
- Back-to-back: a requester still holding req_i in IDLE after its ack was consumed starts a new flush. Requesters must drop req_i in the cycle after ack_o.
- Requester drops req_i before its ack: the snapshot is unaffected and the ack pulse is still issued. This is legal but discouraged.
- served_mask_o = snapshot (valid in FLUSH/ACK).
- busy_o = (state != IDLE).
- Reset mid-operation: immediate return to IDLE, flush_dcache_o=0, no ack issued. Requesters must re-request.
- timeout_o is set only by the watchdog. clear_timeout_i clears it; if set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: DCACHE_FLUSH_ARB_TIMEOUT_EN.
- Defined:
  - a cycle counter of width $clog2(TIMEOUT_CYCLES+1) runs in FLUSH, starting from 0 on entry.
  - when the counter == TIMEOUT_CYCLES-1 and no ack arrives that cycle, go to ACK: acks are issued normally, timeout_o <= 1, and flush_cnt_o does not increment.
  - an ack arriving in that same cycle wins: normal completion, no timeout.
- Undefined:
  - no counter; FLUSH waits indefinitely.
  - timeout_o is tied 0; clear_timeout_i is unused.

Test Plan:
- Single request: req_i=4'b0001 at cycle 0, cache ack at cycle 5 -> flush_dcache_o high cycles 1-5, ack_o=4'b0001 at cycle 6, flush_cnt_o=1, busy_o low at cycle 7.
- Coalescing: req_i=4'b0101 together -> one flush, ack_o=4'b0101 in one cycle, flush_cnt_o=1.
- Late joiner: req_i[0] at cycle 0, req_i[2] at cycle 3 during FLUSH, ack at cycle 5:
  - first flush: ack_o=4'b0001 at cycle 6.
  - second flush: flush_dcache_o high again at cycle 8, served_mask_o=4'b0100.
- Spurious ack in IDLE: flush_dcache_ack_i pulse with req_i=0 -> no state change, no ack_o, flush_cnt_o unchanged.
- Reset mid-flush: rst_ni low at cycle 3 of FLUSH -> flush_dcache_o=0 and ack_o=0 immediately; after release with req_i still high, a new flush starts one cycle later.
- Watchdog (macro defined, TIMEOUT_CYCLES=8): no cache ack -> ack_o pulses 8 cycles after FLUSH entry, timeout_o=1 (sticky), flush_cnt_o=0. clear_timeout_i -> timeout_o=0 next cycle.

Source files
------------

// File: rtl/dcache_flush_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcache_flush_arbiter
// Description : Shares the single dcache flush/ack handshake between NR_REQ
//               independent flush requesters. Concurrent requests are
//               coalesced into one flush; each covered requester receives a
//               one-cycle acknowledge when the flush completes.
//               Optional watchdog (define DCACHE_FLUSH_ARB_TIMEOUT_EN) aborts
//               a flush that the cache never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_flush_arbiter #(
    parameter int NR_REQ         = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NR_REQ-1:0]    req_i,
    output logic [NR_REQ-1:0]    ack_o,
    output logic                 flush_dcache_o,
    input  logic                 flush_dcache_ack_i,
    output logic                 busy_o,
    output logic [NR_REQ-1:0]    served_mask_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic                 timeout_o,
    input  logic                 clear_timeout_i
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_ACK   = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [NR_REQ-1:0]    r_snapshot;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Watchdog expiry: FLUSH has lasted its full budget with no ack this cycle
    logic                 w_wd_expire;

    // A genuine cache acknowledge that ends the current flush
    logic                 w_flush_done;
    assign w_flush_done = (r_state == c_FLUSH) && flush_dcache_ack_i;

`ifdef DCACHE_FLUSH_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Watchdog: counts cycles spent in FLUSH, restarting from zero on entry
    // ------------------------------------------------------------------------
    localparam int               WD_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] c_WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WD_WIDTH-1:0] r_wd_cnt;
    logic                r_timeout;

    // Cycle counter: runs only in FLUSH, held at zero elsewhere so that every
    // FLUSH entry starts a fresh budget
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_FLUSH) begin
            r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // A same-cycle cache ack takes priority over the abort
    assign w_wd_expire = (r_state == c_FLUSH) && (r_wd_cnt == c_WD_LAST)
                         && !flush_dcache_ack_i;

    // Sticky timeout flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeout <= 1'b0;
        end else if (w_wd_expire) begin
            r_timeout <= 1'b1;
        end else if (clear_timeout_i) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout_o = r_timeout;
`else
    // No watchdog: FLUSH waits for the cache indefinitely
    logic w_unused_clear;
    assign w_unused_clear = clear_timeout_i;
    assign w_wd_expire    = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Holds the current arbitration phase; reset returns straight to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // IDLE waits for any request (cache acks are ignored there), FLUSH waits
    // for the cache ack or watchdog expiry, ACK always lasts a single cycle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_IDLE: begin
                if (|req_i) begin
                    w_state_next = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (flush_dcache_ack_i || w_wd_expire) begin
                    w_state_next = c_ACK;
                end
            end
            c_ACK: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (state and registers only, no input feed-through)
    // ------------------------------------------------------------------------
    // Flush request, per-requester acks and busy all derive from the state
    always_comb begin
        flush_dcache_o = 1'b0;
        ack_o          = '0;
        busy_o         = 1'b0;
        unique case (r_state)
            c_IDLE: begin
                busy_o = 1'b0;
            end
            c_FLUSH: begin
                flush_dcache_o = 1'b1;
                busy_o         = 1'b1;
            end
            c_ACK: begin
                ack_o  = r_snapshot;
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Snapshot of the requesters covered by this flush: captured when leaving
    // IDLE, frozen during FLUSH so late joiners wait for the next round, and
    // cleared as ACK hands back to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snapshot <= '0;
        end else if ((r_state == c_IDLE) && (|req_i)) begin
            r_snapshot <= req_i;
        end else if (r_state == c_ACK) begin
            r_snapshot <= '0;
        end
    end

    // Completed-flush counter: bumps on a real cache ack (never on a watchdog
    // abort) and saturates at all-ones; visible from the ACK cycle onward
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_cnt <= '0;
        end else if (w_flush_done && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign served_mask_o = r_snapshot;
    assign flush_cnt_o   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dcache_flush_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_flush_arbiter
// Description : Directed self-checking bench for dcache_flush_arbiter.
//               Counter width is reduced to 2 bits so saturation is reached.
//               Watchdog checks are built when DCACHE_FLUSH_ARB_TIMEOUT_EN
//               is defined (TIMEOUT_CYCLES = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_flush_arbiter;

    localparam int NR_REQ    = 4;
    localparam int CNT_WIDTH = 2;
    localparam int TO_CYC    = 8;

    logic                 clk_i;
    logic                 rst_ni;
    logic [NR_REQ-1:0]    req_i;
    logic [NR_REQ-1:0]    ack_o;
    logic                 flush_dcache_o;
    logic                 flush_dcache_ack_i;
    logic                 busy_o;
    logic [NR_REQ-1:0]    served_mask_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;
    logic                 timeout_o;
    logic                 clear_timeout_i;

    int n_cmp;
    int n_err;

    dcache_flush_arbiter #(
        .NR_REQ         (NR_REQ),
        .TIMEOUT_CYCLES (TO_CYC),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_i              (req_i),
        .ack_o              (ack_o),
        .flush_dcache_o     (flush_dcache_o),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .busy_o             (busy_o),
        .served_mask_o      (served_mask_o),
        .flush_cnt_o        (flush_cnt_o),
        .timeout_o          (timeout_o),
        .clear_timeout_i    (clear_timeout_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one cycle; sampling and driving happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_ni             = 1'b0;
        req_i              = '0;
        flush_dcache_ack_i = 1'b0;
        clear_timeout_i    = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_flush",   {31'd0, flush_dcache_o}, 32'd0);
        chk("rst_ack",     {28'd0, ack_o},          32'd0);
        chk("rst_busy",    {31'd0, busy_o},         32'd0);
        chk("rst_mask",    {28'd0, served_mask_o},  32'd0);
        chk("rst_cnt",     {30'd0, flush_cnt_o},    32'd0);
        chk("rst_timeout", {31'd0, timeout_o},      32'd0);
        rst_ni = 1'b1;
        tick();

        // ---------------- single request ----------------
        req_i = 4'b0001;                                    // cycle 0
        tick();                                             // cycle 1
        chk("single_flush_c1", {31'd0, flush_dcache_o}, 32'd1);
        chk("single_busy_c1",  {31'd0, busy_o},         32'd1);
        chk("single_mask_c1",  {28'd0, served_mask_o},  32'h1);
        tick(); tick(); tick(); tick();                     // cycle 5
        chk("single_flush_c5", {31'd0, flush_dcache_o}, 32'd1);
        chk("single_noack_c5", {28'd0, ack_o},          32'd0);
        flush_dcache_ack_i = 1'b1;
        tick();                                             // cycle 6
        flush_dcache_ack_i = 1'b0;
        chk("single_ack_c6",   {28'd0, ack_o},          32'h1);
        chk("single_flush_c6", {31'd0, flush_dcache_o}, 32'd0);
        chk("single_cnt_c6",   {30'd0, flush_cnt_o},    32'd1);
        req_i = 4'b0000;
        tick();                                             // cycle 7
        chk("single_busy_c7",  {31'd0, busy_o},         32'd0);
        chk("single_ack_c7",   {28'd0, ack_o},          32'd0);
        chk("single_mask_c7",  {28'd0, served_mask_o},  32'd0);

        // ---------------- coalescing ----------------
        req_i = 4'b0101;
        tick();
        chk("coal_mask",  {28'd0, served_mask_o},  32'h5);
        chk("coal_flush", {31'd0, flush_dcache_o}, 32'd1);
        flush_dcache_ack_i = 1'b1;
        tick();
        flush_dcache_ack_i = 1'b0;
        chk("coal_ack",   {28'd0, ack_o},          32'h5);
        chk("coal_cnt",   {30'd0, flush_cnt_o},    32'd2);
        req_i = 4'b0000;
        tick();
        chk("coal_idle",  {31'd0, busy_o},         32'd0);

        // ---------------- late joiner ----------------
        req_i = 4'b0001;                                    // cycle 0
        tick(); tick(); tick();                             // cycle 3
        req_i = 4'b0101;
        tick();                                             // cycle 4
        chk("late_mask_c4", {28'd0, served_mask_o}, 32'h1);
        tick();                                             // cycle 5
        flush_dcache_ack_i = 1'b1;
        tick();                                             // cycle 6
        flush_dcache_ack_i = 1'b0;
        chk("late_ack1_c6", {28'd0, ack_o},          32'h1);
        chk("late_cnt_c6",  {30'd0, flush_cnt_o},    32'd3);
        req_i = 4'b0100;
        tick();                                             // cycle 7
        chk("late_idle_c7",  {31'd0, flush_dcache_o}, 32'd0);
        chk("late_ack_c7",   {28'd0, ack_o},          32'd0);
        tick();                                             // cycle 8
        chk("late_flush_c8", {31'd0, flush_dcache_o}, 32'd1);
        chk("late_mask_c8",  {28'd0, served_mask_o},  32'h4);
        flush_dcache_ack_i = 1'b1;
        tick();                                             // cycle 9
        flush_dcache_ack_i = 1'b0;
        chk("late_ack2_c9",  {28'd0, ack_o},          32'h4);
        chk("cnt_saturated", {30'd0, flush_cnt_o},    32'd3);
        req_i = 4'b0000;
        tick();

        // ---------------- spurious ack in IDLE ----------------
        flush_dcache_ack_i = 1'b1;
        tick();
        flush_dcache_ack_i = 1'b0;
        chk("spur_busy", {31'd0, busy_o},      32'd0);
        chk("spur_ack",  {28'd0, ack_o},       32'd0);
        tick();
        chk("spur_busy2", {31'd0, busy_o},      32'd0);
        chk("spur_cnt",   {30'd0, flush_cnt_o}, 32'd3);

        // ---------------- reset mid-flush ----------------
        req_i = 4'b0010;                                    // cycle 0
        tick(); tick(); tick();                             // cycle 3 of FLUSH
        chk("rmid_flush_before", {31'd0, flush_dcache_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rmid_flush", {31'd0, flush_dcache_o}, 32'd0);
        chk("rmid_ack",   {28'd0, ack_o},          32'd0);
        chk("rmid_busy",  {31'd0, busy_o},         32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rmid_restart_flush", {31'd0, flush_dcache_o}, 32'd1);
        chk("rmid_restart_mask",  {28'd0, served_mask_o},  32'h2);
        chk("rmid_cnt_cleared",   {30'd0, flush_cnt_o},    32'd0);
        flush_dcache_ack_i = 1'b1;
        tick();
        flush_dcache_ack_i = 1'b0;
        chk("rmid_ack_after", {28'd0, ack_o}, 32'h2);
        req_i = 4'b0000;
        tick();

`ifdef DCACHE_FLUSH_ARB_TIMEOUT_EN
        // ---------------- watchdog ----------------
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        req_i = 4'b1000;                                    // cycle 0
        tick();                                             // cycle 1: FLUSH entry
        for (int i = 0; i < TO_CYC - 1; i++) tick();        // cycle 8
        chk("wd_flush_c8", {31'd0, flush_dcache_o}, 32'd1);
        chk("wd_noack_c8", {28'd0, ack_o},          32'd0);
        tick();                                             // cycle 9
        chk("wd_ack_c9",     {28'd0, ack_o},       32'h8);
        chk("wd_timeout_c9", {31'd0, timeout_o},   32'd1);
        chk("wd_cnt_c9",     {30'd0, flush_cnt_o}, 32'd0);
        req_i = 4'b0000;
        tick();
        tick();
        chk("wd_sticky", {31'd0, timeout_o}, 32'd1);
        chk("wd_cnt_idle", {30'd0, flush_cnt_o}, 32'd0);
        clear_timeout_i = 1'b1;
        tick();
        clear_timeout_i = 1'b0;
        chk("wd_cleared", {31'd0, timeout_o}, 32'd0);
`else
        // ---------------- no watchdog: timeout stays low ----------------
        clear_timeout_i = 1'b1;
        tick();
        clear_timeout_i = 1'b0;
        chk("nowd_timeout", {31'd0, timeout_o}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        n_err++;
        $display("FAIL timeout: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
